// File: rtl/pll_drp_ctrl_if.sv
// Request handshake and MMCM DRP bus of the PLL reprogramming controller.
// master: the controller side; slave: requester plus MMCM DRP port.
`timescale 1ns/1ps
interface pll_drp_ctrl_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_req_chan;
    logic [6:0]  i_req_div;
    logic [6:0]  o_daddr;
    logic        o_den;
    logic        o_dwe;
    logic [15:0] o_di;
    logic [15:0] i_do;
    logic        i_drdy;

    modport master (
        input  i_req_valid, i_req_chan, i_req_div, i_do, i_drdy,
        output o_req_ready, o_daddr, o_den, o_dwe, o_di
    );

    modport slave (
        output i_req_valid, i_req_chan, i_req_div, i_do, i_drdy,
        input  o_req_ready, o_daddr, o_den, o_dwe, o_di
    );
endinterface

// File: rtl/pll_drp_ctrl.sv
// MMCM output-divider reprogramming controller: holds the MMCM in reset,
// read-modify-writes ClkReg1 of one CLKOUT over DRP, releases reset and
// waits for lock with bounded retries.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// START     | bring-up reset pulse, RST_CYCLES clocks, no DRP access
// IDLE      | locked and ready, accepts requests
// HOLD_RST  | MMCM held in reset RST_CYCLES clocks (DRP skipped on retry)
// RD        | one-clock DRP read strobe of ClkReg1
// WAIT_RD   | wait for DRDY of the read, bounded by DRP_TIMEOUT
// WR        | one-clock DRP write strobe with new high/low counts
// WAIT_WR   | wait for DRDY of the write, bounded by DRP_TIMEOUT
// RELEASE   | one clock with MMCM reset released, lock timer cleared
// WAIT_LOCK | wait for synchronised LOCKED, bounded by LOCK_TIMEOUT
`timescale 1ns/1ps
module pll_drp_ctrl #(
    parameter int unsigned CHAN_TOTAL   = 2,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned DRP_TIMEOUT  = 255,
    parameter int unsigned RETRY_MAX    = 3
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    pll_drp_ctrl_if.master bus,
    output logic           o_pll_rst,
    input  logic           i_pll_locked,
    output logic           o_locked,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic [1:0]     o_err_code,
    output logic [7:0]     o_lock_loss_cnt
);
    typedef enum logic [3:0] {
        START, IDLE, HOLD_RST, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK
    } state_t;

    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] DRP_LAST  = 32'(DRP_TIMEOUT - 1);
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]  CHAN_LIM  = 4'(CHAN_TOTAL);

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic [7:0]  retries;
    logic [2:0]  chan_q;
    logic [6:0]  div_q;
    logic [3:0]  rd_keep;
    logic        sync_meta, locked, lock_q;
    logic        retry_clr, retry_inc, latch_req, cap_rd, done_set, err_set;
    logic [1:0]  err_code_nxt;
    logic        req_bad;
    logic [6:0]  div_high, div_low, reg_addr;

    assign req_bad  = (bus.i_req_div < 7'd2) || ({1'b0, bus.i_req_chan} >= CHAN_LIM);
    // Low half takes the odd remainder; a count of 64 wraps to 0 in 6 bits.
    assign div_high = {1'b0, div_q[6:1]};
    assign div_low  = div_q - div_high;

    // ClkReg1 address of each CLKOUT (CLKOUT5 sits below CLKOUT0).
    always_comb begin
        reg_addr = 7'h00;
        case (chan_q)
            3'd0: reg_addr = 7'h08;
            3'd1: reg_addr = 7'h0A;
            3'd2: reg_addr = 7'h0C;
            3'd3: reg_addr = 7'h0E;
            3'd4: reg_addr = 7'h10;
            3'd5: reg_addr = 7'h06;
            3'd6: reg_addr = 7'h12;
            default: reg_addr = 7'h00;
        endcase
    end

    // Two-flop synchroniser for the asynchronous MMCM LOCKED.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync_meta <= 1'b0;
            locked    <= 1'b0;
        end else begin
            sync_meta <= i_pll_locked;
            locked    <= sync_meta;
        end
    end

    // State register plus one shared wait counter, cleared on every state change.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= START;
            cnt   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE)
                cnt <= 32'd0;
            else
                cnt <= cnt + 32'd1;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt    = state;
        retry_clr    = 1'b0;
        retry_inc    = 1'b0;
        latch_req    = 1'b0;
        cap_rd       = 1'b0;
        done_set     = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = 2'd0;
        case (state)
            START: begin
                if (cnt == RST_LAST) begin
                    state_nxt = RELEASE;
                    retry_clr = 1'b1;
                end
            end
            IDLE: begin
                if (bus.i_req_valid) begin
                    if (req_bad) begin
                        err_set      = 1'b1;
                        err_code_nxt = 2'd1;
                    end else begin
                        latch_req = 1'b1;
                        retry_clr = 1'b1;
                        state_nxt = HOLD_RST;
                    end
                end
            end
            HOLD_RST: begin
                // A non-zero retry count marks a lock retry: the divider is already written.
                if (cnt == RST_LAST)
                    state_nxt = (retries != 8'd0) ? RELEASE : RD;
            end
            RD: state_nxt = WAIT_RD;
            WAIT_RD: begin
                if (bus.i_drdy) begin
                    cap_rd    = 1'b1;
                    state_nxt = WR;
                end else if (cnt == DRP_LAST) begin
                    err_set      = 1'b1;
                    err_code_nxt = 2'd2;
                    state_nxt    = RELEASE;
                end
            end
            WR: state_nxt = WAIT_WR;
            WAIT_WR: begin
                if (bus.i_drdy) begin
                    state_nxt = RELEASE;
                end else if (cnt == DRP_LAST) begin
                    err_set      = 1'b1;
                    err_code_nxt = 2'd2;
                    state_nxt    = RELEASE;
                end
            end
            RELEASE: state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (locked) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == LOCK_LAST) begin
                    if ({24'd0, retries} < RETRY_MAX) begin
                        retry_inc = 1'b1;
                        state_nxt = HOLD_RST;
                    end else begin
                        err_set      = 1'b1;
                        err_code_nxt = 2'd3;
                        state_nxt    = IDLE;
                    end
                end
            end
            default: state_nxt = START;
        endcase
    end

    // Request latch, DRP read capture and retry count.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            chan_q  <= 3'd0;
            div_q   <= 7'd0;
            rd_keep <= 4'd0;
            retries <= 8'd0;
        end else begin
            if (latch_req) begin
                chan_q <= bus.i_req_chan;
                div_q  <= bus.i_req_div;
            end
            if (cap_rd)
                rd_keep <= bus.i_do[15:12];
            if (retry_clr)
                retries <= 8'd0;
            else if (retry_inc)
                retries <= retries + 8'd1;
        end
    end

    // Status pulses, held error code and saturating lock-loss counter.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_done          <= 1'b0;
            o_err           <= 1'b0;
            o_err_code      <= 2'd0;
            o_lock_loss_cnt <= 8'd0;
            lock_q          <= 1'b0;
        end else begin
            o_done <= done_set;
            o_err  <= err_set;
            if (err_set)
                o_err_code <= err_code_nxt;
            lock_q <= locked;
            if (state == IDLE && lock_q && !locked && o_lock_loss_cnt != 8'hFF)
                o_lock_loss_cnt <= o_lock_loss_cnt + 8'd1;
        end
    end

    // Outputs decode from state so a reset assertion drops them without a clock.
    assign o_pll_rst       = state inside {START, HOLD_RST, RD, WAIT_RD, WR, WAIT_WR};
    assign bus.o_den       = (state == RD) || (state == WR);
    assign bus.o_dwe       = (state == WR);
    assign bus.o_daddr     = bus.o_den ? reg_addr : 7'h00;
    assign bus.o_di        = (state == WR) ? {rd_keep, div_high[5:0], div_low[5:0]} : 16'h0000;
    assign bus.o_req_ready = (state == IDLE);
    assign o_busy          = (state != IDLE);
    assign o_locked        = locked && (state == IDLE);
endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: MMCM lock/DRP responder, bus monitor and a
// directed-plus-random request sequence checked against a spec-level model.
`timescale 1ns/1ps
module tb_pll_drp_ctrl;
    localparam int CHAN_TOTAL   = 2;
    localparam int RST_CYCLES   = 16;
    localparam int LOCK_TIMEOUT = 200;
    localparam int DRP_TIMEOUT  = 255;
    localparam int RETRY_MAX    = 3;
    localparam int LOCK_DLY     = 100;

    logic       clk;
    logic       nrst;
    logic       pll_rst, pll_locked;
    logic       o_locked, o_busy, o_done, o_err;
    logic [1:0] o_err_code;
    logic [7:0] o_lock_loss_cnt;

    pll_drp_ctrl_if bus();

    pll_drp_ctrl #(
        .CHAN_TOTAL(CHAN_TOTAL), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .DRP_TIMEOUT(DRP_TIMEOUT), .RETRY_MAX(RETRY_MAX)
    ) dut (
        .i_clk(clk), .i_nrst(nrst), .bus(bus),
        .o_pll_rst(pll_rst), .i_pll_locked(pll_locked),
        .o_locked(o_locked), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_err_code(o_err_code), .o_lock_loss_cnt(o_lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // responder controls
    int          lock_mode = 0;   // 0 auto lock, 1 never lock, 2 manual
    logic        lock_man  = 1'b0;
    int          drp_mode  = 0;   // 0 answer, 1 never answer
    int          drp_lat   = 2;
    logic [15:0] do_val    = 16'h0000;

    // monitor results
    int          cyc = 0, n_rd = 0, n_wr = 0, n_done = 0, n_err = 0, n_rise = 0;
    int          rst_run = 0, last_rst_len = 0, rd_time = 0, err_time = 0;
    logic [6:0]  rd_addr = 7'h00, wr_addr = 7'h00;
    logic [15:0] wr_di = 16'h0000;
    logic [1:0]  err_seen = 2'd0;
    bit          prev_rst = 1'b0;

    logic [1:0]  exp_code = 2'd0;
    logic [6:0]  addr_tbl [7] = '{7'h08, 7'h0A, 7'h0C, 7'h0E, 7'h10, 7'h06, 7'h12};

    function automatic logic [15:0] exp_di(input int div, input logic [15:0] dov);
        int hi, lo;
        hi = div / 2;
        lo = div - hi;
        return {dov[15:12], 6'(hi % 64), 6'(lo % 64)};
    endfunction

    // MMCM model: LOCKED rises LOCK_DLY clocks after reset falls; DRDY after drp_lat clocks.
    initial begin
        int pend, lk;
        pend = 0;
        lk   = 0;
        bus.i_drdy = 1'b0;
        bus.i_do   = 16'h0000;
        pll_locked = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_drdy = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.i_drdy = 1'b1;
                    bus.i_do   = do_val;
                end
            end
            if (bus.o_den === 1'b1 && drp_mode == 0)
                pend = drp_lat;
            case (lock_mode)
                0: begin
                    if (pll_rst !== 1'b0) begin
                        pll_locked = 1'b0;
                        lk = 0;
                    end else if (lk < LOCK_DLY) begin
                        lk++;
                        if (lk == LOCK_DLY) pll_locked = 1'b1;
                    end
                end
                1: begin
                    pll_locked = 1'b0;
                    lk = 0;
                end
                default: begin
                    pll_locked = lock_man;
                    lk = LOCK_DLY;
                end
            endcase
        end
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (bus.o_den === 1'b1) begin
            if (bus.o_dwe === 1'b1) begin
                n_wr++;
                wr_addr = bus.o_daddr;
                wr_di   = bus.o_di;
            end else begin
                n_rd++;
                rd_addr = bus.o_daddr;
                rd_time = cyc;
            end
        end
        if (pll_rst === 1'b1) begin
            if (!prev_rst) begin
                n_rise++;
                rst_run = 1;
            end else begin
                rst_run++;
            end
        end else if (prev_rst) begin
            last_rst_len = rst_run;
        end
        prev_rst = (pll_rst === 1'b1);
        if (o_done === 1'b1) n_done++;
        if (o_err === 1'b1) begin
            n_err++;
            err_seen = o_err_code;
            err_time = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int bound);
        int s, k;
        s = n_done;
        k = 0;
        while (n_done == s && k < bound) begin
            tick(1);
            k++;
        end
    endtask

    task automatic wait_err(input int bound);
        int s, k;
        s = n_err;
        k = 0;
        while (n_err == s && k < bound) begin
            tick(1);
            k++;
        end
    endtask

    task automatic send(input logic [2:0] chan, input logic [6:0] div);
        chk("req_ready", bus.o_req_ready, 1);
        bus.i_req_chan  = chan;
        bus.i_req_div   = div;
        bus.i_req_valid = 1'b1;
        tick(1);
        bus.i_req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [2:0] chan, input logic [6:0] div,
                           input logic [15:0] dov, input int lat);
        int s_rd, s_wr, s_done, s_err, s_rise;
        bit bad;
        s_rd = n_rd; s_wr = n_wr; s_done = n_done; s_err = n_err; s_rise = n_rise;
        do_val  = dov;
        drp_lat = lat;
        bad = (div < 2) || (int'(chan) >= CHAN_TOTAL);
        send(chan, div);
        if (bad) begin
            tick(3);
            exp_code = 2'd1;
            chk("bad_err_pulses", n_err - s_err, 1);
            chk("bad_err_code", err_seen, exp_code);
            chk("bad_no_den", n_rd - s_rd, 0);
            chk("bad_no_pll_rst", n_rise - s_rise, 0);
            chk("bad_stays_idle", bus.o_req_ready, 1);
        end else begin
            wait_done(1000);
            tick(1);
            chk("req_done", n_done - s_done, 1);
            chk("req_no_err", n_err - s_err, 0);
            chk("req_reads", n_rd - s_rd, 1);
            chk("req_writes", n_wr - s_wr, 1);
            chk("req_rd_addr", rd_addr, addr_tbl[chan]);
            chk("req_wr_addr", wr_addr, addr_tbl[chan]);
            chk("req_wr_di", wr_di, exp_di(int'(div), dov));
            chk("req_code_held", o_err_code, exp_code);
            chk("req_locked", o_locked, 1);
        end
    endtask

    initial begin
        int n, s_rd, s_wr, s_done, s_err, s_rise, toggles;
        nrst = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.i_req_chan  = 3'd0;
        bus.i_req_div   = 7'd0;
        tick(3);

        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_den", bus.o_den, 0);
        chk("rst_dwe", bus.o_dwe, 0);
        chk("rst_daddr", bus.o_daddr, 0);
        chk("rst_di", bus.o_di, 0);
        chk("rst_ready", bus.o_req_ready, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_code", o_err_code, 0);
        chk("rst_llc", o_lock_loss_cnt, 0);

        // bring-up
        nrst = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            n++;
            tick(1);
        end
        chk("bringup_rst_len", n, RST_CYCLES);
        s_rd = n_rd;
        wait_done(500);
        chk("bringup_done", o_done, 1);
        chk("bringup_locked", o_locked, 1);
        chk("bringup_ready", bus.o_req_ready, 1);
        chk("bringup_busy", o_busy, 0);
        chk("bringup_no_drp", n_rd - s_rd, 0);
        tick(1);
        chk("done_one_clock", o_done, 0);

        // directed requests and boundaries
        run_req(3'd1, 7'd25, 16'hF123, 2);
        run_req(3'd0, 7'd1, 16'h1234, 1);
        run_req(3'd2, 7'd10, 16'h1234, 1);
        run_req(3'd0, 7'd2, 16'hA5A5, 1);
        run_req(3'd1, 7'd127, 16'h5AFF, 3);
        run_req(3'd0, 7'd64, 16'h0FFF, 4);
        run_req(3'd7, 7'd50, 16'h0000, 1);
        run_req(3'd1, 7'd0, 16'h0000, 1);

        // random requests
        for (int i = 0; i < 16; i++)
            run_req(3'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
                    16'($urandom), int'($urandom_range(1, 5)));

        // DRP hang: no DRDY for the read
        drp_mode = 1;
        s_rd = n_rd; s_wr = n_wr; s_err = n_err; s_done = n_done;
        send(3'd0, 7'd10);
        wait_err(1000);
        chk("hang_err_pulses", n_err - s_err, 1);
        chk("hang_err_code", err_seen, 2);
        chk("hang_reads", n_rd - s_rd, 1);
        chk("hang_no_write", n_wr - s_wr, 0);
        chk("hang_wait_len", err_time - rd_time, 1 + DRP_TIMEOUT);
        drp_mode = 0;
        exp_code = 2'd2;
        wait_done(1000);
        chk("hang_relock_done", n_done - s_done, 1);
        tick(1);
        chk("hang_code_held", o_err_code, exp_code);

        // lock failure with retries
        lock_mode = 1;
        s_rise = n_rise; s_err = n_err; s_done = n_done;
        send(3'd1, 7'd4);
        wait_err(3000);
        tick(1);
        exp_code = 2'd3;
        chk("lf_err_pulses", n_err - s_err, 1);
        chk("lf_err_code", err_seen, exp_code);
        chk("lf_code_out", o_err_code, exp_code);
        chk("lf_rst_pulses", n_rise - s_rise, 1 + RETRY_MAX);
        chk("lf_retry_len", last_rst_len, RST_CYCLES);
        chk("lf_no_done", n_done - s_done, 0);
        chk("lf_not_locked", o_locked, 0);
        chk("lf_idle", bus.o_req_ready, 1);
        lock_mode = 0;
        tick(LOCK_DLY + 10);
        chk("lf_relocked_idle", o_locked, 1);

        // lock loss counting in IDLE
        chk("ll_start", o_lock_loss_cnt, 0);
        lock_man  = 1'b1;
        lock_mode = 2;
        toggles = 0;
        for (int i = 0; i < 300; i++) begin
            lock_man = 1'b0;
            tick(4);
            lock_man = 1'b1;
            tick(4);
            toggles++;
            if (i == 9) chk("ll_10", o_lock_loss_cnt, toggles);
        end
        chk("ll_saturate", o_lock_loss_cnt, (toggles > 255) ? 255 : toggles);
        lock_mode = 0;

        // reset asserted while the DRP write strobe is high
        drp_lat = 2;
        send(3'd0, 7'd9);
        n = 0;
        while (bus.o_dwe !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk("ar_write_reached", bus.o_dwe, 1);
        nrst = 1'b0;
        #1;
        chk("ar_den", bus.o_den, 0);
        chk("ar_dwe", bus.o_dwe, 0);
        chk("ar_daddr", bus.o_daddr, 0);
        chk("ar_di", bus.o_di, 0);
        chk("ar_pll_rst", pll_rst, 1);
        chk("ar_ready", bus.o_req_ready, 0);
        chk("ar_llc", o_lock_loss_cnt, 0);
        chk("ar_code", o_err_code, 0);
        chk("ar_busy", o_busy, 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
